tour_cmd_seq: RTL and testbench



---
 rtl/tour_pkg.sv | 33 +++
 rtl/tour_move_decode.sv | 46 ++++
 rtl/tour_cmd_seq.sv | 164 ++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// -----------------------------------------------------------------------------
// tour_pkg
// Shared types and constants for the knight's-tour command sequencer.
//   state_t      : sequencer FSM states
//   OP_*         : command opcodes ([15:12] of a command word)
//   HDG_*        : heading field values ([11:4] of a command word)
//   RESP_*       : response bytes returned to the UART/BLE wrapper
// -----------------------------------------------------------------------------
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLDV,
    HORZ,
    HOLDH
  } state_t;

  localparam int NUM_MOVES_DEF = 24;

  localparam logic [3:0] OP_MOVE    = 4'b0010;  // move, no fanfare
  localparam logic [3:0] OP_MOVE_FF = 4'b0011;  // move with fanfare
  localparam logic [3:0] OP_ABORT   = 4'hF;     // tour abort request from UART

  localparam logic [7:0] HDG_N = 8'h00;  // +y
  localparam logic [7:0] HDG_W = 8'h3F;  // -x
  localparam logic [7:0] HDG_S = 8'h7F;  // -y
  localparam logic [7:0] HDG_E = 8'hBF;  // +x

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;

endpackage

// File: rtl/tour_move_decode.sv
// -----------------------------------------------------------------------------
// tour_move_decode
// Combinational decode of a one-hot knight move into two move commands.
//   move[7:0]      in  : one-hot move (lowest set bit wins if several are set)
//   vert_cmd[15:0] out : vertical leg, opcode OP_MOVE, heading N/S, |dy| squares
//   horz_cmd[15:0] out : horizontal leg, opcode OP_MOVE_FF, heading E/W, |dx|
//   move_vld       out : at least one bit of move is set
// -----------------------------------------------------------------------------
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        move_vld
);

  logic       dy_pos;
  logic [3:0] dy_abs;
  logic       dx_pos;
  logic [3:0] dx_abs;

  // Each knight move is (+/-2,+/-1) or (+/-1,+/-2); pick the lowest set bit.
  always_comb begin
    dy_pos   = 1'b1;
    dy_abs   = 4'd0;
    dx_pos   = 1'b1;
    dx_abs   = 4'd0;
    move_vld = 1'b1;
    casez (move)
      8'b???????1: begin dy_pos = 1'b1; dy_abs = 4'd2; dx_pos = 1'b1; dx_abs = 4'd1; end
      8'b??????10: begin dy_pos = 1'b1; dy_abs = 4'd2; dx_pos = 1'b0; dx_abs = 4'd1; end
      8'b?????100: begin dy_pos = 1'b0; dy_abs = 4'd1; dx_pos = 1'b0; dx_abs = 4'd2; end
      8'b????1000: begin dy_pos = 1'b1; dy_abs = 4'd1; dx_pos = 1'b0; dx_abs = 4'd2; end
      8'b???10000: begin dy_pos = 1'b0; dy_abs = 4'd2; dx_pos = 1'b0; dx_abs = 4'd1; end
      8'b??100000: begin dy_pos = 1'b0; dy_abs = 4'd2; dx_pos = 1'b1; dx_abs = 4'd1; end
      8'b?1000000: begin dy_pos = 1'b1; dy_abs = 4'd1; dx_pos = 1'b1; dx_abs = 4'd2; end
      8'b10000000: begin dy_pos = 1'b0; dy_abs = 4'd1; dx_pos = 1'b1; dx_abs = 4'd2; end
      default:     move_vld = 1'b0;
    endcase
  end

  assign vert_cmd = {OP_MOVE,    (dy_pos ? HDG_N : HDG_S), dy_abs};
  assign horz_cmd = {OP_MOVE_FF, (dx_pos ? HDG_E : HDG_W), dx_abs};

endmodule

// File: rtl/tour_cmd_seq.sv
// -----------------------------------------------------------------------------
// tour_cmd_seq
// Sequences a stored knight's tour into the command processor. While idle the
// command processor sees the UART/BLE command path; on start_tour the block
// walks mv_indx 0..NUM_MOVES-1 and issues a vertical then a horizontal move
// command per stored move, waiting for clr_cmd_rdy and send_resp on each.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start_tour          : 1-clk pulse starting a tour (ignored while touring)
//   move[7:0]           : one-hot move read from tour memory at mv_indx
//   mv_indx[4:0]        : index of the current move
//   cmd_UART[15:0]      : command from UART wrapper
//   cmd_rdy_UART        : UART command valid
//   clr_cmd_rdy_UART    : consume UART command
//   cmd[15:0], cmd_rdy  : command and valid to the command processor
//   clr_cmd_rdy         : command processor consumed cmd
//   send_resp           : command processor finished a command
//   resp[7:0]           : response byte to UART wrapper
//
// Optional build macro TOUR_ABORT_EN: a UART command with opcode 4'hF during a
// tour is consumed and makes the next send_resp end the tour.
// -----------------------------------------------------------------------------
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = NUM_MOVES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;

  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        move_vld;
  logic        last_move;
  logic        abort_flag;   // pending abort, ends the tour at next send_resp
  logic        abort_req;    // UART abort command present this cycle

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .move_vld (move_vld)
  );

  assign last_move = (mv_indx_q == LAST_INDX);
  assign mv_indx   = mv_indx_q;

`ifdef TOUR_ABORT_EN
  logic abort_q, abort_d;

  assign abort_req  = cmd_rdy_UART && (cmd_UART[15:12] == OP_ABORT);
  assign abort_flag = abort_q;

  always_comb begin
    abort_d = abort_q;
    if (state_d == IDLE) begin
      abort_d = 1'b0;
    end else if (state_q != IDLE && abort_req) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
`else
  assign abort_req  = 1'b0;
  assign abort_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;

    case (state_q)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          mv_indx_d = 5'd0;
          state_d   = VERT;
        end
      end

      VERT: begin
        cmd              = vert_cmd;
        clr_cmd_rdy_UART = abort_req;
        // An empty move slot marks an early end of the tour.
        if (!move_vld) begin
          state_d = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = HOLDV;
        end
      end

      HOLDV: begin
        clr_cmd_rdy_UART = abort_req;
        if (abort_flag) resp = RESP_DONE;
        if (send_resp) state_d = abort_flag ? IDLE : HORZ;
      end

      HORZ: begin
        cmd              = horz_cmd;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = abort_req;
        if (clr_cmd_rdy) state_d = HOLDH;
      end

      HOLDH: begin
        clr_cmd_rdy_UART = abort_req;
        if (last_move || abort_flag) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move || abort_flag) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = VERT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_tour_cmd_seq
// Bench for tour_cmd_seq: a decode table of fixed moves, randomised full tours
// against a move-geometry reference model, and hand sequences for early end,
// mid-tour reset and the optional abort (TOUR_ABORT_EN).
// -----------------------------------------------------------------------------
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0] moves [24];
  bit         uart_pend;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  // Knight displacement for each move bit.
  int dy_t [8] = '{2, 2, -1, 1, -2, -2, 1, -1};
  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } dec_vec_t;

  dec_vec_t tbl [10];

  always #10 clk = ~clk;

  assign move = moves[mv_indx];

  tour_cmd_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: command words from knight geometry.
  function automatic void ref_cmds(input logic [7:0] m, output logic [15:0] v,
                                   output logic [15:0] h);
    int b, dy, dx;
    b = 0;
    while (b < 7 && !m[b]) b++;
    dy = dy_t[b];
    dx = dx_t[b];
    v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
    h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_start();
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
  endtask

  task automatic wait_rdy(input string nm);
    int k;
    k = 0;
    while (!cmd_rdy && k < 10) begin
      cyc();
      k++;
    end
    if (!cmd_rdy) chk(nm, {31'd0, cmd_rdy}, 32'd1);
  endtask

  task automatic hold_wait(input int idx);
    int d;
    d = $urandom_range(15, 25);
    for (int k = 0; k < d; k++) begin
      if (idx == 10 && k == 3) start_tour = 1'b1;
      cyc();
      start_tour = 1'b0;
      #1;
      if (uart_pend) chk("uart_held", {31'd0, clr_cmd_rdy_UART}, 32'd0);
    end
  endtask

  task automatic do_move(input int idx, input logic [15:0] ev, input logic [15:0] eh,
                         input bit last, input bit stop_h);
    wait_rdy("vert_rdy_timeout");
    chk("vert_cmd", {16'd0, cmd}, {16'd0, ev});
    chk("vert_indx", {27'd0, mv_indx}, 32'(idx));
    chk("vert_resp", {24'd0, resp}, 32'h5A);
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("holdv_rdy", {31'd0, cmd_rdy}, 32'd0);
    hold_wait(idx);
    send_resp = 1'b1;
    #1;
    chk("vert_send_resp", {24'd0, resp}, 32'h5A);
    cyc();
    send_resp = 1'b0;
    #1;
    wait_rdy("horz_rdy_timeout");
    chk("horz_cmd", {16'd0, cmd}, {16'd0, eh});
    chk("horz_indx", {27'd0, mv_indx}, 32'(idx));
    if (!stop_h) begin
      clr_cmd_rdy = 1'b1;
      cyc();
      clr_cmd_rdy = 1'b0;
      #1;
      chk("holdh_rdy", {31'd0, cmd_rdy}, 32'd0);
      hold_wait(idx);
      send_resp = 1'b1;
      #1;
      chk("horz_send_resp", {24'd0, resp}, last ? 32'hA5 : 32'h5A);
      cyc();
      send_resp = 1'b0;
      #1;
    end
    $display("move %0d: mv=%h vert=%h horz=%h", idx, moves[idx], ev, eh);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) moves[i] = 8'(1 << $urandom_range(7, 0));
      else moves[i] = 8'($urandom_range(255, 1));
    end
  endtask

  task automatic run_moves(input int first, input int last_idx);
    logic [15:0] ev, eh;
    for (int i = first; i <= last_idx; i++) begin
      ref_cmds(moves[i], ev, eh);
      do_move(i, ev, eh, (i == 23), 1'b0);
    end
  endtask

  initial begin
    logic [15:0] ev, eh;

    tbl[0] = '{8'h01, 16'h2002, 16'h3BF1};
    tbl[1] = '{8'h02, 16'h2002, 16'h33F1};
    tbl[2] = '{8'h04, 16'h27F1, 16'h33F2};
    tbl[3] = '{8'h08, 16'h2001, 16'h33F2};
    tbl[4] = '{8'h10, 16'h27F2, 16'h33F1};
    tbl[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    tbl[6] = '{8'h40, 16'h2001, 16'h3BF2};
    tbl[7] = '{8'h80, 16'h27F1, 16'h3BF2};
    tbl[8] = '{8'h05, 16'h2002, 16'h3BF1};
    tbl[9] = '{8'hF0, 16'h27F2, 16'h33F1};

    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    uart_pend    = 1'b0;
    for (int i = 0; i < 24; i++) moves[i] = 8'h01;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;

    // Reset state: UART pass-through.
    chk("rst_indx", {27'd0, mv_indx}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'hBEEF);
    chk("rst_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("rst_resp", {24'd0, resp}, 32'hA5);

    // Idle pass-through with consume.
    cmd_UART    = 16'h2001;
    clr_cmd_rdy = 1'b1;
    #1;
    chk("idle_cmd", {16'd0, cmd}, 32'h2001);
    chk("idle_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    chk("idle_resp", {24'd0, resp}, 32'hA5);
    cyc();
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("idle_clr_off", {31'd0, clr_cmd_rdy_UART}, 32'd0);
    chk("idle_rdy_off", {31'd0, cmd_rdy}, 32'd0);

    // Decode table: one move each, stop after the horizontal command shows.
    for (int t = 0; t < 10; t++) begin
      moves[0] = tbl[t].mv;
      do_reset();
      do_start();
      do_move(0, tbl[t].v, tbl[t].h, 1'b0, 1'b1);
    end

    // Random full tours with a UART command left pending throughout.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      do_reset();
      do_start();
      cmd_UART     = 16'h2001;
      cmd_rdy_UART = 1'b1;
      uart_pend    = 1'b1;
      run_moves(0, 23);
      uart_pend = 1'b0;
      chk("tour_end_cmd", {16'd0, cmd}, 32'h2001);
      chk("tour_end_rdy", {31'd0, cmd_rdy}, 32'd1);
      chk("tour_end_indx", {27'd0, mv_indx}, 32'd23);
      chk("tour_end_resp", {24'd0, resp}, 32'hA5);
      cmd_rdy_UART = 1'b0;
    end

    // Early end: empty slot at index 3.
    fill_random();
    moves[3] = 8'h00;
    do_reset();
    do_start();
    run_moves(0, 2);
    chk("early_vert_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("early_vert_indx", {27'd0, mv_indx}, 32'd3);
    cyc();
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("early_idle_cmd", {16'd0, cmd}, 32'h1234);
    chk("early_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("early_idle_indx", {27'd0, mv_indx}, 32'd3);
    cmd_rdy_UART = 1'b0;

    // Reset while in HORZ at mv_indx 7.
    fill_random();
    do_reset();
    do_start();
    run_moves(0, 6);
    ref_cmds(moves[7], ev, eh);
    do_move(7, ev, eh, 1'b0, 1'b1);
    cmd_UART     = 16'h4321;
    cmd_rdy_UART = 1'b1;
    rst_n        = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_indx", {27'd0, mv_indx}, 32'd0);
    chk("midrst_cmd", {16'd0, cmd}, 32'h4321);
    chk("midrst_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("midrst_resp", {24'd0, resp}, 32'hA5);
    cmd_rdy_UART = 1'b0;
    #1;
    chk("midrst_rdy_follow", {31'd0, cmd_rdy}, 32'd0);

    // Abort command arriving in HOLDV.
    moves[0] = 8'h01;
    do_reset();
    do_start();
    wait_rdy("abort_rdy_timeout");
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy  = 1'b0;
    cmd_UART     = 16'hF000;
    cmd_rdy_UART = 1'b1;
    #1;
`ifdef TOUR_ABORT_EN
    chk("abort_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
    cyc();
    cmd_rdy_UART = 1'b0;
    #1;
    chk("abort_resp", {24'd0, resp}, 32'hA5);
    send_resp = 1'b1;
    cyc();
    send_resp    = 1'b0;
    cmd_UART     = 16'h2001;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("abort_idle_cmd", {16'd0, cmd}, 32'h2001);
    chk("abort_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
`else
    chk("noabort_clr", {31'd0, clr_cmd_rdy_UART}, 32'd0);
    cyc();
    chk("noabort_resp", {24'd0, resp}, 32'h5A);
    send_resp = 1'b1;
    cyc();
    send_resp = 1'b0;
    #1;
    chk("noabort_horz_cmd", {16'd0, cmd}, 32'h3BF1);
    chk("noabort_horz_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("noabort_still_held", {31'd0, clr_cmd_rdy_UART}, 32'd0);
`endif
    cmd_rdy_UART = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
